// File: rtl/cfa_writeback_fifo_if.sv
// cfa_writeback_fifo_if: write-request, frame-memory and status signals of the CFA write-back stage.
interface cfa_writeback_fifo_if #(
    parameter int addressBitWidth = 17,
    parameter int dataBitWidth    = 12
);
    logic                         frameStart;
    logic                         frameEnd;
    logic [addressBitWidth-1:0]   writeAddress;
    logic [2:0]                   writeEnable;
    logic [dataBitWidth-1:0]      greenWrite;
    logic [dataBitWidth-1:0]      redWrite;
    logic [dataBitWidth-1:0]      blueWrite;
    logic [addressBitWidth-1:0]   memAddress;
    logic [3*dataBitWidth-1:0]    memData;
    logic [2:0]                   memMask;
    logic                         memValid;
    logic                         memReady;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic                         overflow;
    logic                         protocolError;
    logic                         addrError;
    logic [addressBitWidth-1:0]   pixelsWritten;
    logic                         frameComplete;

    modport master (
        output frameStart, frameEnd, writeAddress, writeEnable, greenWrite, redWrite, blueWrite, memReady,
        input  memAddress, memData, memMask, memValid, fifoFull, fifoEmpty, overflow, protocolError,
               addrError, pixelsWritten, frameComplete
    );

    modport slave (
        input  frameStart, frameEnd, writeAddress, writeEnable, greenWrite, redWrite, blueWrite, memReady,
        output memAddress, memData, memMask, memValid, fifoFull, fifoEmpty, overflow, protocolError,
               addrError, pixelsWritten, frameComplete
    );
endinterface

// File: rtl/cfa_writeback_fifo.sv
// cfa_writeback_fifo: frame-sequenced RGB write-back FIFO draining to frame memory over valid/ready.
// Define CFA_WB_ADDR_CHECK_EN to build the ascending-address checker behind addrError.
module cfa_writeback_fifo #(
    parameter int addressBitWidth = 17,
    parameter int dataBitWidth    = 12,
    parameter int fifoDepth       = 8,
    parameter int ptrBitWidth     = 3
) (
    input logic                 clk,
    input logic                 rst,
    cfa_writeback_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    typedef struct packed {
        logic [addressBitWidth-1:0] addr;
        logic [2:0]                 mask;
        logic [3*dataBitWidth-1:0]  data;
    } entry_t;

    localparam logic [ptrBitWidth:0] full_lvl = (ptrBitWidth + 1)'(fifoDepth);

    state_t                     state_q, state_d;
    entry_t                     mem_q [fifoDepth];
    entry_t                     mem_d [fifoDepth];
    logic [ptrBitWidth-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ptrBitWidth:0]       count_q, count_d;
    logic [addressBitWidth-1:0] pix_q, pix_d;
    logic                       ovf_q, ovf_d, perr_q, perr_d;
    logic                       push, win, valid, full, pop, push_ok, start;
    entry_t                     entry, head;

    always_comb begin
        push    = |bus.writeEnable;
        win     = (state_q == RUN) || (state_q == FLUSH);
        valid   = count_q != '0;
        full    = count_q == full_lvl;
        pop     = valid & bus.memReady;
        push_ok = push & win & (!full | pop);
        start   = (state_q == IDLE) & bus.frameStart;
        entry.addr = bus.writeAddress;
        entry.mask = bus.writeEnable;
        entry.data = {bus.writeEnable[2] ? bus.greenWrite : '0,
                      bus.writeEnable[1] ? bus.redWrite   : '0,
                      bus.writeEnable[0] ? bus.blueWrite  : '0};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.frameStart ? RUN : IDLE;
            RUN:     state_d = bus.frameEnd ? FLUSH : RUN;
            FLUSH:   state_d = (!valid && !push) ? DONE : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = entry;
        wr_ptr_d = wr_ptr_q + ptrBitWidth'(push_ok);
        rd_ptr_d = rd_ptr_q + ptrBitWidth'(pop);
        count_d  = count_q + (ptrBitWidth + 1)'(push_ok) - (ptrBitWidth + 1)'(pop);
        pix_d    = start ? '0 : (pop && pix_q != '1) ? pix_q + addressBitWidth'(1) : pix_q;
        ovf_d    = (ovf_q & !start) | (push & win & full & !pop);
        // frameStart while running is flagged even when frameEnd wins the same cycle
        perr_d   = (perr_q & !start) | (push & !win) | ((state_q == RUN) & bus.frameStart);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pix_q    <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pix_q    <= pix_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk)
        mem_q <= mem_d;

`ifdef CFA_WB_ADDR_CHECK_EN
    logic [addressBitWidth-1:0] last_q, last_d;
    logic                       seen_q, seen_d, aerr_q, aerr_d;

    always_comb begin
        last_d = push_ok ? bus.writeAddress : last_q;
        seen_d = (seen_q & !start) | push_ok;
        aerr_d = (aerr_q & !start) | (push_ok & seen_q & (bus.writeAddress <= last_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            seen_q <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            last_q <= last_d;
            seen_q <= seen_d;
            aerr_q <= aerr_d;
        end
    end

    assign bus.addrError = aerr_q;
`else
    assign bus.addrError = 1'b0;
`endif

    // head fields are gated so an empty FIFO presents all-zero memory outputs
    assign head              = mem_q[rd_ptr_q];
    assign bus.memValid      = valid;
    assign bus.memAddress    = valid ? head.addr : '0;
    assign bus.memMask       = valid ? head.mask : '0;
    assign bus.memData       = valid ? head.data : '0;
    assign bus.fifoFull      = full;
    assign bus.fifoEmpty     = !valid;
    assign bus.overflow      = ovf_q;
    assign bus.protocolError = perr_q;
    assign bus.pixelsWritten = pix_q;
    assign bus.frameComplete = state_q == DONE;
endmodule

// File: tb/tb_cfa_writeback_fifo.sv
// tb_cfa_writeback_fifo: cycle table plus hand sequences; a scoreboard queue checks every memory pop.
module tb_cfa_writeback_fifo;
    localparam int AW = 17;
    localparam int DW = 12;
`ifdef CFA_WB_ADDR_CHECK_EN
    localparam logic AERR = 1'b1;
`else
    localparam logic AERR = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [2:0]      mask;
        logic [3*DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          fs, fe;
        logic [2:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] g;
        logic          rdy, acc;
        logic [5:0]    st;
        logic [AW-1:0] pix;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sbq[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    cfa_writeback_fifo_if #(.addressBitWidth(AW), .dataBitWidth(DW)) bus ();
    cfa_writeback_fifo dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic fe, input logic [2:0] we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] g, input logic rdy, input logic acc);
        bus.frameStart   = fs;
        bus.frameEnd     = fe;
        bus.writeEnable  = we;
        bus.writeAddress = addr;
        bus.greenWrite   = g;
        bus.redWrite     = g + 12'h001;
        bus.blueWrite    = g + 12'h002;
        bus.memReady     = rdy;
        if (acc)
            sbq.push_back('{addr, we, {we[2] ? g : 12'h0, we[1] ? g + 12'h001 : 12'h0, we[0] ? g + 12'h002 : 12'h0}});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // st = {memValid, fifoFull, fifoEmpty, overflow, protocolError, frameComplete}
    task automatic add(input int fs, input int fe, input int we, input int addr, input int g,
                       input int rdy, input int acc, input int st, input int pix);
        vec_t v;
        v.fs = fs[0]; v.fe = fe[0]; v.we = we[2:0]; v.addr = AW'(addr); v.g = DW'(g);
        v.rdy = rdy[0]; v.acc = acc[0]; v.st = st[5:0]; v.pix = AW'(pix);
        vecs.push_back(v);
    endtask

    function automatic logic [5:0] status();
        return {bus.memValid, bus.fifoFull, bus.fifoEmpty, bus.overflow, bus.protocolError, bus.frameComplete};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.memValid && bus.memReady) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got addr %0h expected no pop", bus.memAddress);
            end else begin
                e = sbq.pop_front();
                chk("pop", 64'({bus.memAddress, bus.memMask, bus.memData}), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        add(0, 0, 7, 1, 'h111, 0, 0, 'b001010, 0);
        add(1, 0, 0, 0, 0, 0, 0, 'b001000, 0);
        add(0, 0, 4, 5, 'h7A0, 1, 1, 'b100000, 0);
        add(0, 0, 0, 0, 0, 1, 0, 'b001000, 1);
        for (int a = 0; a < 8; a++)
            add(0, 0, 7, a, 'h100 + a, 0, 1, (a == 7) ? 'b110000 : 'b100000, 1);
        add(0, 0, 2, 20, 'h0AB, 1, 1, 'b110000, 2);
        add(0, 0, 7, 8, 'h108, 0, 0, 'b110100, 2);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 0, 0, 1, 0, (j < 8) ? 'b100100 : 'b001100, 2 + j);
        add(0, 1, 0, 0, 0, 1, 0, 'b001100, 10);
        add(0, 0, 0, 0, 0, 0, 0, 'b001101, 10);
        add(0, 0, 0, 0, 0, 0, 0, 'b001100, 10);
        add(1, 0, 0, 0, 0, 0, 0, 'b001000, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 1, 30 + k, 'h300 + k, 0, 1, 'b100000, 0);
        add(0, 1, 0, 0, 0, 1, 0, 'b100000, 1);
        add(0, 0, 7, 33, 'h333, 1, 1, 'b100000, 2);
        add(0, 0, 0, 0, 0, 1, 0, 'b100000, 3);
        add(0, 0, 7, 34, 'h344, 1, 1, 'b100000, 4);
        add(0, 0, 0, 0, 0, 1, 0, 'b001000, 5);
        add(0, 0, 0, 0, 0, 1, 0, 'b001001, 5);
        add(0, 0, 0, 0, 0, 0, 0, 'b001000, 5);
        add(1, 0, 0, 0, 0, 0, 0, 'b001000, 0);
        add(1, 1, 0, 0, 0, 0, 0, 'b001010, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'b001011, 0);
        add(0, 0, 0, 0, 0, 0, 0, 'b001010, 0);

        drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst_held", 64'({status(), bus.addrError}), 64'(7'b0010000));
        rst = 1'b0;
        step();
        chk("rst_status", 64'({status(), bus.addrError}), 64'(7'b0010000));
        chk("rst_mem", 64'({bus.memAddress, bus.memMask, bus.memData}), 64'(0));
        chk("rst_pix", 64'(bus.pixelsWritten), 64'(0));

        foreach (vecs[i]) begin
            drive(vecs[i].fs, vecs[i].fe, vecs[i].we, vecs[i].addr, vecs[i].g, vecs[i].rdy, vecs[i].acc);
            step();
            chk($sformatf("row%0d", i), 64'({status(), bus.pixelsWritten}), 64'({vecs[i].st, vecs[i].pix}));
        end

        drive(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        step();
        chk("as_perr_clear", 64'(bus.protocolError), 64'(0));
        drive(1'b0, 1'b0, 3'd7, AW'(10), 12'h0A0, 1'b1, 1'b1);
        step();
        chk("as_first", 64'(bus.addrError), 64'(0));
        drive(1'b0, 1'b0, 3'd7, AW'(9), 12'h0B0, 1'b1, 1'b1);
        step();
        chk("as_order", 64'(bus.addrError), 64'(AERR));
        drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        step();
        chk("as_drained", 64'({bus.fifoEmpty, bus.addrError, bus.pixelsWritten}), 64'({1'b1, AERR, AW'(2)}));

        drive(1'b0, 1'b0, 3'd7, AW'(50), 12'h500, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd7, AW'(51), 12'h510, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        chk("mid_loaded", 64'({bus.memValid, bus.fifoEmpty}), 64'(2'b10));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst", 64'({status(), bus.addrError, bus.pixelsWritten}), 64'({7'b0010000, AW'(0)}));
        sbq.delete();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd7, AW'(52), 12'h520, 1'b1, 1'b0);
        step();
        chk("mid_idle_push", 64'({bus.protocolError, bus.fifoEmpty, bus.memValid}), 64'(3'b110));
        drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        step();
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cfa_writeback_fifo.md
Name: cfa_writeback_fifo

Overview:
- Downstream write-back stage of the CFA demosaic core.
- Accepts per-pixel RGB write requests (writeAddress, writeEnable[2:0], greenWrite/redWrite/blueWrite) from the interpolation core.
- Buffers them in a small FIFO and drains them to the frame-memory port over a valid/ready handshake.
- Tracks frame start/end, counts written pixels, and reports overflow and protocol errors.

Parameters:
- addressBitWidth, 17, pixel address width.
- dataBitWidth, 12, per-channel pixel width.
- fifoDepth, 8, entries; power of two, at least 2.
- ptrBitWidth, 3, log2(fifoDepth).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- frameStart  input  1  one-cycle pulse; starts a frame.
- frameEnd  input  1  one-cycle pulse; upstream `done`, no more pixels will be generated.
- writeAddress  input  addressBitWidth  pixel address.
- writeEnable  input  3  channel enables: [2]=green, [1]=red, [0]=blue.
- greenWrite, redWrite, blueWrite  input  dataBitWidth each  pixel channel values.
- memAddress  output  addressBitWidth  head-entry address.
- memData  output  3*dataBitWidth  {green, red, blue}; disabled channels are zero.
- memMask  output  3  head-entry writeEnable copy.
- memValid  output  1  head entry valid.
- memReady  input  1  memory accepts head entry.
- fifoFull  output  1  occupancy equals fifoDepth.
- fifoEmpty  output  1  occupancy equals 0.
- overflow  output  1  sticky; a push was dropped.
- protocolError  output  1  sticky; a push arrived outside RUN/FLUSH.
- addrError  output  1  sticky; see Optional Feature.
- pixelsWritten  output  addressBitWidth  count of accepted pops this frame.
- frameComplete  output  1  one-cycle pulse.

Behaviour:
- Reset (async): state=IDLE; pointers and count=0; every output 0 except fifoEmpty=1.
- Push = |writeEnable.
- Pop = memValid & memReady.
- Occupancy counter is 0..fifoDepth. Pointers wrap modulo fifoDepth.
- Storage is registered. An entry pushed at edge N is visible at the head (memValid=1, if the FIFO was empty) after edge N. First-word latency is 1 cycle.
- memAddress/memData/memMask come directly from the head entry; they are stable while memValid=1 and memReady=0.
- State machine:
  - IDLE: frameStart -> RUN; clears pixelsWritten, overflow, protocolError, addrError. A push in IDLE is dropped and sets protocolError.
  - RUN: pushes accepted. frameEnd -> FLUSH. frameStart in RUN is ignored and sets protocolError.
  - FLUSH: pushes still accepted, to absorb the upstream 3-cycle write pipeline tail. Pops continue. When the FIFO is empty and there is no push that cycle -> DONE.
  - DONE: frameComplete=1 for exactly this cycle -> IDLE.
- Full: a push while full with no pop in the same cycle is dropped and sets overflow; FIFO contents are unchanged. A push and pop in the same cycle while full are both accepted; occupancy stays at fifoDepth.
- Empty: memValid=0 and the pop is ignored. A push and memReady in the same cycle while empty: the push is accepted, nothing pops, and the entry appears next cycle.
- pixelsWritten increments on each pop and saturates at all-ones.
- frameEnd and frameStart arriving in the same cycle in RUN: frameEnd wins and protocolError is set.
- A reset mid-frame discards all FIFO contents. No partial handshake is completed.

Optional Feature:
- Macro: CFA_WB_ADDR_CHECK_EN.
- When defined: each accepted push whose writeAddress is not greater than the previous accepted push address (within the frame) sets addrError, sticky until the next frameStart. The entry is still queued. The first push after frameStart is never flagged.
- When undefined: addrError is tied to 0 and no comparator or last-address register is built.

Test Plan:
- Reset: hold rst during clocking, release -> all outputs 0, fifoEmpty=1, state IDLE.
- Basic flow: frameStart; push addr 5, mask 3'b100, G=12'h7A0; memReady=1 -> next cycle memValid=1, memAddress=5, memData={12'h7A0,12'h0,12'h0}; one cycle later memValid=0, pixelsWritten=1.
- Overflow: memReady=0; 9 pushes (addr 0..8) -> fifoFull after the 8th, overflow=1; draining yields addresses 0..7 only.
- Full push+pop: with the FIFO full, push addr 20 and memReady=1 in the same cycle -> overflow stays 0; addr 20 emerges as the 8th pop after.
- Flush/complete: frameEnd with 3 queued entries plus 2 trailing pushes over the next 3 cycles; memReady=1 -> all 5 popped, then frameComplete pulses once, pixelsWritten=5, then IDLE.
- Protocol/address: push in IDLE -> protocolError=1, nothing queued. With CFA_WB_ADDR_CHECK_EN, pushes addr 10 then 9 -> addrError=1; both entries are still drained.
